// File: rtl/cdb_arbiter_pkg.sv
// Shared defaults and types for the common-data-bus arbiter.
// ROB_WIDTH / DATA_WIDTH / ZERO_ROB / CDB_FIFO_DEPTH fall back to local defaults when no constant file is present.
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ZERO_ROB
`define ZERO_ROB 0
`endif
`ifndef CDB_FIFO_DEPTH
`define CDB_FIFO_DEPTH 4
`endif

package cdb_arbiter_pkg;
    localparam int CDB_ROB_W    = `ROB_WIDTH;
    localparam int CDB_DATA_W   = `DATA_WIDTH;
    localparam int CDB_DEPTH    = `CDB_FIFO_DEPTH;
    localparam int CDB_ZERO_ROB = `ZERO_ROB;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;
endpackage

// File: rtl/cdb_result_fifo.sv
// Per-source result FIFO holding {rob_tag, data}; head is visible combinationally.
// Asynchronous active-low reset plus a synchronous clear used for mispredict flush.
module cdb_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; only entries behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr_reg] <= din;
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: buffers ALU and LSB results, round-robin arbitrates, broadcasts one tag/data per cycle.
// Define CDB_BYPASS_EN to let a winning source with an empty FIFO broadcast its input directly.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = CDB_DEPTH,
    parameter int ROB_W      = CDB_ROB_W,
    parameter int DATA_W     = CDB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [ROB_W-1:0]  alu_rob_tag,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsb_valid,
    input  logic [ROB_W-1:0]  lsb_rob_tag,
    input  logic [DATA_W-1:0] lsb_data,
    output logic              lsb_ready,
    output logic [ROB_W-1:0]  newest_data_rob_tag,
    output logic [DATA_W-1:0] newest_data,
    output logic              cdb_valid
);
    localparam int EW = ROB_W + DATA_W;
    localparam logic [ROB_W-1:0] ZERO_TAG = ROB_W'(CDB_ZERO_ROB);

    logic              alu_full, alu_empty, lsb_full, lsb_empty;
    logic [EW-1:0]     alu_head, lsb_head, grant_entry;
    logic              alu_live, lsb_live, alu_req, lsb_req;
    logic              grant_alu, grant_lsb, contended, arb_en;
    logic              alu_bypass, lsb_bypass;
    logic              alu_push, lsb_push, alu_pop, lsb_pop;
    cdb_src_e          last_grant_reg;
    logic [ROB_W-1:0]  tag_reg;
    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;

    assign alu_ready = ~alu_full;
    assign lsb_ready = ~lsb_full;
    assign arb_en    = ena & ~flush;

    // Zero-tag results complete the handshake but never become live.
    assign alu_live = alu_valid & alu_ready & arb_en & (alu_rob_tag != ZERO_TAG);
    assign lsb_live = lsb_valid & lsb_ready & arb_en & (lsb_rob_tag != ZERO_TAG);

`ifdef CDB_BYPASS_EN
    assign alu_req = ~alu_empty | alu_live;
    assign lsb_req = ~lsb_empty | lsb_live;
`else
    assign alu_req = ~alu_empty;
    assign lsb_req = ~lsb_empty;
`endif

    assign contended = alu_req & lsb_req;
    assign grant_alu = arb_en & alu_req & (~lsb_req | (last_grant_reg == SRC_LSB));
    assign grant_lsb = arb_en & lsb_req & (~alu_req | (last_grant_reg == SRC_ALU));

    // A grant to an empty FIFO can only come from the bypass requester.
    assign alu_bypass = grant_alu & alu_empty;
    assign lsb_bypass = grant_lsb & lsb_empty;
    assign alu_pop    = grant_alu & ~alu_empty;
    assign lsb_pop    = grant_lsb & ~lsb_empty;
    assign alu_push   = alu_live & ~alu_bypass;
    assign lsb_push   = lsb_live & ~lsb_bypass;

    always_comb begin
        grant_entry = '0;
        if (grant_alu)
            grant_entry = alu_bypass ? {alu_rob_tag, alu_data} : alu_head;
        else if (grant_lsb)
            grant_entry = lsb_bypass ? {lsb_rob_tag, lsb_data} : lsb_head;
    end

    cdb_result_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (alu_push),
        .pop   (alu_pop),
        .din   ({alu_rob_tag, alu_data}),
        .head  (alu_head),
        .full  (alu_full),
        .empty (alu_empty)
    );

    cdb_result_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (lsb_push),
        .pop   (lsb_pop),
        .din   ({lsb_rob_tag, lsb_data}),
        .head  (lsb_head),
        .full  (lsb_full),
        .empty (lsb_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_reg        <= ZERO_TAG;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            last_grant_reg <= SRC_LSB;
        end else if (flush) begin
            tag_reg        <= ZERO_TAG;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            last_grant_reg <= SRC_LSB;
        end else if (ena) begin
            if (grant_alu || grant_lsb) begin
                tag_reg   <= grant_entry[EW-1:DATA_W];
                data_reg  <= grant_entry[DATA_W-1:0];
                valid_reg <= 1'b1;
                if (contended)
                    last_grant_reg <= grant_alu ? SRC_ALU : SRC_LSB;
            end else begin
                tag_reg   <= ZERO_TAG;
                data_reg  <= '0;
                valid_reg <= 1'b0;
            end
        end
    end

    assign newest_data_rob_tag = tag_reg;
    assign newest_data         = data_reg;
    assign cdb_valid           = valid_reg;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build, CDB_BYPASS_EN only alters the first latency check).
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int ROB_W  = CDB_ROB_W;
    localparam int DATA_W = CDB_DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ena = 1'b1;
    logic              flush = 1'b0;
    logic              alu_valid = 1'b0;
    logic [ROB_W-1:0]  alu_rob_tag = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              alu_ready;
    logic              lsb_valid = 1'b0;
    logic [ROB_W-1:0]  lsb_rob_tag = '0;
    logic [DATA_W-1:0] lsb_data = '0;
    logic              lsb_ready;
    logic [ROB_W-1:0]  newest_data_rob_tag;
    logic [DATA_W-1:0] newest_data;
    logic              cdb_valid;

    int checks = 0;
    int fails  = 0;
    int bq[$];

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .ena                 (ena),
        .flush               (flush),
        .alu_valid           (alu_valid),
        .alu_rob_tag         (alu_rob_tag),
        .alu_data            (alu_data),
        .alu_ready           (alu_ready),
        .lsb_valid           (lsb_valid),
        .lsb_rob_tag         (lsb_rob_tag),
        .lsb_data            (lsb_data),
        .lsb_ready           (lsb_ready),
        .newest_data_rob_tag (newest_data_rob_tag),
        .newest_data         (newest_data),
        .cdb_valid           (cdb_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (cdb_valid === 1'b1) begin
            bq.push_back(int'(newest_data_rob_tag));
            $display("cdb broadcast tag=%0d data=0x%0h", newest_data_rob_tag, newest_data);
        end
    endtask

    task automatic drive_alu(input bit v, input int tag);
        alu_valid   = v;
        alu_rob_tag = ROB_W'(tag);
        alu_data    = DATA_W'(tag * 16 + 1);
    endtask

    task automatic drive_lsb(input bit v, input int tag);
        lsb_valid   = v;
        lsb_rob_tag = ROB_W'(tag);
        lsb_data    = DATA_W'(tag * 16 + 2);
    endtask

    task automatic do_reset();
        drive_alu(0, 0);
        drive_lsb(0, 0);
        ena = 1'b1;
        flush = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if (cdb_valid !== 1'b0 || newest_data_rob_tag !== ROB_W'(CDB_ZERO_ROB) || newest_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b tag=%0d data=%0h required 0/0/0", cdb_valid, newest_data_rob_tag, newest_data);
        end
        checks++;
        if (alu_ready !== 1'b1 || lsb_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got alu=%b lsb=%b required 1/1", alu_ready, lsb_ready);
        end
        do_reset();
    endtask

    task automatic test_single_latency();
        logic exp_v1;
        do_reset();
        drive_alu(1, 3);
        alu_data = 32'h11;
        step();
        drive_alu(0, 0);
`ifdef CDB_BYPASS_EN
        exp_v1 = 1'b1;
`else
        exp_v1 = 1'b0;
`endif
        checks++;
        if (cdb_valid !== exp_v1) begin
            fails++;
            $display("FAIL latency_edge1: got valid=%b required %b", cdb_valid, exp_v1);
        end
`ifndef CDB_BYPASS_EN
        step();
`endif
        checks++;
        if (cdb_valid !== 1'b1 || newest_data_rob_tag !== ROB_W'(3) || newest_data !== DATA_W'(32'h11)) begin
            fails++;
            $display("FAIL single_broadcast: got valid=%b tag=%0d data=%0h required 1/3/11", cdb_valid, newest_data_rob_tag, newest_data);
        end
        step();
        checks++;
        if (cdb_valid !== 1'b0 || newest_data_rob_tag !== ROB_W'(CDB_ZERO_ROB) || newest_data !== '0) begin
            fails++;
            $display("FAIL single_idle_after: got valid=%b tag=%0d data=%0h required 0/0/0", cdb_valid, newest_data_rob_tag, newest_data);
        end
    endtask

    task automatic test_round_robin();
        int exp[6] = '{1, 5, 2, 6, 3, 7};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_alu(1, 1 + i);
            drive_lsb(1, 5 + i);
            step();
        end
        drive_alu(0, 0);
        drive_lsb(0, 0);
        repeat (6) step();
        checks++;
        if (bq.size() != 6) begin
            fails++;
            $display("FAIL rr_count: got %0d broadcasts required 6", bq.size());
        end
        for (int i = 0; i < 6 && i < bq.size(); i++) begin
            checks++;
            if (bq[i] != exp[i]) begin
                fails++;
                $display("FAIL rr_order[%0d]: got tag %0d required %0d", i, bq[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp[7] = '{19, 4, 20, 5, 21, 6, 22};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive_alu(1, 1 + k);
            drive_lsb(1, 17 + k);
            checks++;
            if (lsb_ready !== 1'b1) begin
                fails++;
                $display("FAIL bp_ready_before_edge%0d: got %b required 1", k + 1, lsb_ready);
            end
            step();
        end
        checks++;
        if (lsb_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_full: got lsb_ready=%b required 0", lsb_ready);
        end
        ena = 1'b0;
        drive_alu(0, 0);
        drive_lsb(1, 23);
        repeat (3) step();
        checks++;
        if (lsb_ready !== 1'b0 || cdb_valid !== 1'b1 || newest_data_rob_tag !== ROB_W'(3)) begin
            fails++;
            $display("FAIL bp_hold: got ready=%b valid=%b tag=%0d required 0/1/3", lsb_ready, cdb_valid, newest_data_rob_tag);
        end
        bq.delete();
        ena = 1'b1;
        step();
        drive_lsb(0, 0);
        checks++;
        if (lsb_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready_rise: got lsb_ready=%b required 1", lsb_ready);
        end
        repeat (8) step();
        checks++;
        if (bq.size() != 7) begin
            fails++;
            $display("FAIL bp_drain_count: got %0d broadcasts required 7", bq.size());
        end
        for (int i = 0; i < 7 && i < bq.size(); i++) begin
            checks++;
            if (bq[i] != exp[i]) begin
                fails++;
                $display("FAIL bp_drain[%0d]: got tag %0d required %0d", i, bq[i], exp[i]);
            end
        end
    endtask

    task automatic test_zero_tag();
        do_reset();
        drive_alu(1, 0);
        alu_data = 32'hFF;
        checks++;
        if (alu_ready !== 1'b1) begin
            fails++;
            $display("FAIL zero_ready: got %b required 1", alu_ready);
        end
        step();
        drive_alu(0, 0);
        repeat (4) step();
        checks++;
        if (bq.size() != 0) begin
            fails++;
            $display("FAIL zero_tag_broadcast: got %0d broadcasts required 0", bq.size());
        end
    endtask

    task automatic test_flush();
        int exp[2] = '{9, 25};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_alu(1, 1 + k);
            drive_lsb(1, 17 + k);
            step();
        end
        flush = 1'b1;
        drive_alu(1, 7);
        drive_lsb(1, 23);
        step();
        flush = 1'b0;
        drive_alu(0, 0);
        drive_lsb(0, 0);
        checks++;
        if (cdb_valid !== 1'b0 || newest_data_rob_tag !== ROB_W'(CDB_ZERO_ROB) || newest_data !== '0) begin
            fails++;
            $display("FAIL flush_idle: got valid=%b tag=%0d data=%0h required 0/0/0", cdb_valid, newest_data_rob_tag, newest_data);
        end
        checks++;
        if (alu_ready !== 1'b1 || lsb_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_ready: got alu=%b lsb=%b required 1/1", alu_ready, lsb_ready);
        end
        bq.delete();
        repeat (6) step();
        checks++;
        if (bq.size() != 0) begin
            fails++;
            $display("FAIL flush_stale: got %0d broadcasts required 0", bq.size());
        end
        drive_alu(1, 9);
        drive_lsb(1, 25);
        step();
        drive_alu(0, 0);
        drive_lsb(0, 0);
        repeat (3) step();
        checks++;
        if (bq.size() != 2 || bq[0] != exp[0] || bq[1] != exp[1]) begin
            fails++;
            $display("FAIL flush_pointer: got %0d broadcasts first=%0d required 2 starting 9,25", bq.size(), (bq.size() > 0) ? bq[0] : -1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_alu(1, 1 + k);
            drive_lsb(1, 17 + k);
            step();
        end
        checks++;
        if (cdb_valid !== 1'b1) begin
            fails++;
            $display("FAIL arst_busy: got valid=%b required 1", cdb_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || newest_data_rob_tag !== ROB_W'(CDB_ZERO_ROB) || newest_data !== '0) begin
            fails++;
            $display("FAIL arst_immediate: got valid=%b tag=%0d data=%0h required 0/0/0", cdb_valid, newest_data_rob_tag, newest_data);
        end
        drive_alu(0, 0);
        drive_lsb(0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bq.delete();
        repeat (5) step();
        checks++;
        if (bq.size() != 0 || alu_ready !== 1'b1 || lsb_ready !== 1'b1) begin
            fails++;
            $display("FAIL arst_release: got %0d broadcasts ready=%b/%b required 0 and 1/1", bq.size(), alu_ready, lsb_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_round_robin();
        test_backpressure();
        test_zero_tag();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
